// File: rtl/iterative_divider.sv
// Purpose: multi-cycle restoring divider (quotient + remainder), one trial subtraction per clock.
// Latency: BIT_COUNT+1 cycles from accepted start to done; 1 cycle for a zero divisor.
// Backpressure: none queued; start is ignored while busy, the core stalls on busy.
// Optional feature: SIGNED_DIV_EN adds a signed_op input for two's-complement division.
module iterative_divider #(
  parameter int BIT_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_COUNT-1:0] dividend,
  input  logic [BIT_COUNT-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic                 signed_op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [BIT_COUNT-1:0] quotient,
  output logic [BIT_COUNT-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(BIT_COUNT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(BIT_COUNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  // Working registers: partial remainder, dividend/quotient shift register, iteration count.
  logic [BIT_COUNT-1:0] r_rem;
  logic [BIT_COUNT-1:0] r_quo;
  logic [BIT_COUNT-1:0] r_divisor;
  logic [CW-1:0]        r_count;
  logic                 r_neg_q;
  logic                 r_neg_r;

  // Result registers, held between completed operations.
  logic [BIT_COUNT-1:0] r_quotient;
  logic [BIT_COUNT-1:0] r_remainder;
  logic                 r_div_by_zero;

  logic                 w_signed_op;
  logic                 w_dividend_neg;
  logic                 w_divisor_neg;
  logic [BIT_COUNT-1:0] w_abs_dividend;
  logic [BIT_COUNT-1:0] w_abs_divisor;
  logic                 w_divisor_zero;

  logic [BIT_COUNT:0]   w_shift_rem;
  logic [BIT_COUNT:0]   w_trial;
  logic                 w_borrow;
  logic                 w_unused_trial_msb;
  logic [BIT_COUNT-1:0] w_rem_next;
  logic [BIT_COUNT-1:0] w_quo_next;
  logic [BIT_COUNT-1:0] w_q_final;
  logic [BIT_COUNT-1:0] w_r_final;

`ifdef SIGNED_DIV_EN
  assign w_signed_op = signed_op;
`else
  assign w_signed_op = 1'b0;
`endif

  // Operand conditioning: signed division works on magnitudes and fixes signs at the end.
  // The most negative value maps to itself, which as an unsigned magnitude is correct.
  assign w_dividend_neg = w_signed_op & dividend[BIT_COUNT-1];
  assign w_divisor_neg  = w_signed_op & divisor[BIT_COUNT-1];
  assign w_abs_dividend = w_dividend_neg ? (-dividend) : dividend;
  assign w_abs_divisor  = w_divisor_neg ? (-divisor) : divisor;
  assign w_divisor_zero = (divisor == '0);

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The shifted remainder is at most 2*divisor-1, so it needs one extra bit.
  assign w_shift_rem = {r_rem, r_quo[BIT_COUNT-1]};
  assign {w_borrow, w_trial} = {1'b0, w_shift_rem} - {2'b00, r_divisor};
  // A successful trial always leaves a value below the divisor, so its top bit is zero.
  assign w_unused_trial_msb = w_trial[BIT_COUNT];
  assign w_rem_next = w_borrow ? w_shift_rem[BIT_COUNT-1:0] : w_trial[BIT_COUNT-1:0];
  assign w_quo_next = {r_quo[BIT_COUNT-2:0], ~w_borrow};

  // Sign fix-up applied on the last step so results are ready in the DONE cycle.
  assign w_q_final = r_neg_q ? (-w_quo_next) : w_quo_next;
  assign w_r_final = r_neg_r ? (-w_rem_next) : w_rem_next;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_divisor_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_count == CNT_ONE) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, iterate in RUN, commit results entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_divisor     <= '0;
      r_count       <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem         <= '0;
            r_quo         <= w_abs_dividend;
            r_divisor     <= w_abs_divisor;
            r_count       <= CNT_INIT;
            r_neg_q       <= w_dividend_neg ^ w_divisor_neg;
            r_neg_r       <= w_dividend_neg;
            r_div_by_zero <= w_divisor_zero;
            // A zero divisor skips iteration: results are defined directly.
            if (w_divisor_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) begin
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider (BIT_COUNT=8): stimulus pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_iterative_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_op;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  iterative_divider #(.BIT_COUNT(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SIGNED_DIV_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_issued = 0;
  int           n_done = 0;
  int           cyc = 0;
  bit           noise_en = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: plain integer division, signed truncates toward zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sb;
    int   qi;
    int   ri;
    e.a = a; e.b = b; e.s = s; e.acc = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      e.q = qi[W-1:0]; e.r = ri[W-1:0]; e.dbz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Wait for idle (optionally pulsing start with junk while busy), then launch one divide.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      if (noise_en && ($urandom_range(0, 1) == 1)) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        signed_op = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      check("idle_wait_timeout", 1, 0);
      start = 1'b0;
      return;
    end
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    e         = model(a, b, s);
    // Accepted on the next rising edge, i.e. when cyc becomes cyc+1.
    e.acc     = cyc + 1;
    sb_q.push_back(e);
    n_issued++;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", sb_q.size(), 0);
  endtask

  // Monitor: compare each done pulse against the oldest expectation; results hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_q = '0;
      last_r = '0;
    end else if (done) begin
      n_done++;
      check("busy_with_done", int'(busy), 1);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.dbz));
        // Done is seen in the cycle after the final iteration edge.
        check("latency", cyc - e.acc, e.dbz ? 0 : W);
        if (!e.s && e.b != 0) begin
          check("invariant_sum", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
          check("invariant_rem_lt", int'(remainder < e.b), 1);
        end
      end
      last_q = quotient;
      last_r = remainder;
    end else begin
      check("hold_quotient", int'(quotient), int'(last_q));
      check("hold_remainder", int'(remainder), int'(last_r));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    signed_op = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;

    // Directed cases, with junk start pulses while busy from the second case on.
    issue(8'd200, 8'd7, 1'b0);
    noise_en = 1;
    issue(8'd255, 8'd1, 1'b0);
    issue(8'd5, 8'd9, 1'b0);
    issue(8'd42, 8'd0, 1'b0);
    wait_drain();

    // Reset in the middle of RUN: everything clears at once and no done follows.
    noise_en = 0;
    issue(8'd100, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_dbz", int'(div_by_zero), 0);
    n_issued -= sb_q.size();
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);

`ifdef SIGNED_DIV_EN
    issue(8'hF9, 8'd2, 1'b1);
    issue(8'd7, 8'hFE, 1'b1);
    issue(8'h80, 8'hFF, 1'b1);
    issue(8'hF9, 8'd0, 1'b1);
    issue(8'hF9, 8'd2, 1'b0);
    wait_drain();
`endif

    // Random unsigned pairs with a nonzero divisor.
    for (int i = 0; i < 1000; i++) begin
      noise_en = ($urandom_range(0, 3) == 0);
      issue(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)), 1'b0);
    end
    wait_drain();

    // Mixed tail including zero divisors (and signed mode when present).
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] b;
      logic         s;
      b = (i % 5 == 0) ? 8'd0 : W'($urandom);
`ifdef SIGNED_DIV_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      issue(W'($urandom), b, s);
    end
    wait_drain();
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("done_count", n_done, n_issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
